// File: rtl/pc_fetch_unit_if.sv
// Fetch-PC bundle between the PC generator and the IMEM/IF-ID side.
// Control inputs come in; fetch request, status and counters go out.
interface pc_fetch_unit_if #(
  parameter int XLEN        = 64,
  parameter int STALL_CNT_W = 16
);
  logic             stall_i;
  logic             redirect_i;
  logic [XLEN-1:0]  redirect_pc_i;
  logic             trap_i;
  logic             halt_i;
  logic             resume_i;
  logic             fetch_ready_i;
  logic [XLEN-1:0]  pc_o;
  logic             pc_valid_o;
  logic [XLEN-1:0]  pc_next_seq_o;
  logic [1:0]       state_o;
  logic [STALL_CNT_W-1:0] stall_cycles_o;
  logic             misalign_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i,
    input  trap_i, halt_i, resume_i, fetch_ready_i,
    output pc_o, pc_valid_o, pc_next_seq_o,
    output state_o, stall_cycles_o, misalign_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i,
    output trap_i, halt_i, resume_i, fetch_ready_i,
    input  pc_o, pc_valid_o, pc_next_seq_o,
    input  state_o, stall_cycles_o, misalign_o
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// IF-stage PC generator: boot bubble, stall, redirect, trap, halt/resume.
// Define PC_ALIGN_CHECK_EN to vector misaligned redirects to TRAP_VECTOR.
module pc_fetch_unit #(
  parameter int             XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int             INST_BYTES   = 4,
  parameter int             STALL_CNT_W  = 16
) (
  input  logic         clk,
  input  logic         reset,
  pc_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  localparam logic [XLEN-1:0] INC = XLEN'(INST_BYTES);

  state_t                 state;
  logic [XLEN-1:0]        pc;
  logic [XLEN-1:0]        pc_nxt;
  logic [XLEN-1:0]        seq;
  logic                   valid;
  logic [STALL_CNT_W-1:0] cnt;
  logic                   hold;
  logic                   flush;
  logic                   bad_target;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [XLEN-1:0] MASK = XLEN'(INST_BYTES - 1);
  logic mis;

  assign bad_target = bus.redirect_i &&
                      |(bus.redirect_pc_i & MASK);
  assign bus.misalign_o = mis;

  // Trap outranks the alignment fault, so no pulse then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mis <= 1'b0;
    else       mis <= bad_target & ~bus.trap_i;
  end
`else
  assign bad_target     = 1'b0;
  assign bus.misalign_o = 1'b0;
`endif

  assign hold  = bus.stall_i | ~bus.fetch_ready_i;
  assign flush = bus.trap_i | bus.redirect_i;
  assign seq   = pc + INC;

  always_comb begin
    pc_nxt = pc;
    if (bus.trap_i)
      pc_nxt = TRAP_VECTOR;
    else if (bus.redirect_i)
      pc_nxt = bad_target ? TRAP_VECTOR
                          : bus.redirect_pc_i;
    else if (state == RUN && !hold)
      pc_nxt = seq;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      valid <= 1'b0;
      pc    <= RESET_VECTOR;
      cnt   <= '0;
    end else begin
      pc <= pc_nxt;
      if (flush)
        cnt <= '0;
      else if (state == RUN && hold && cnt != '1)
        cnt <= cnt + 1'b1;
      unique case (state)
        BOOT: begin
          state <= RUN;
          valid <= 1'b1;
        end
        RUN: if (bus.halt_i) begin
          state <= HALT;
          valid <= 1'b0;
        end
        HALT: if (bus.resume_i) begin
          state <= RUN;
          valid <= 1'b1;
        end
        default: begin
          state <= BOOT;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_o           = pc;
  assign bus.pc_valid_o     = valid;
  assign bus.pc_next_seq_o  = seq;
  assign bus.state_o        = state;
  assign bus.stall_cycles_o = cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: driver queues hand-computed
// expectations, a monitor pops and compares one per clock.
module tb_pc_fetch_unit;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit AC = 1'b1;
`else
  localparam bit AC = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] pc;
    logic        v;
    logic [1:0]  s;
    logic [15:0] c;
    logic        m;
  } obs_t;

  typedef struct {
    int   id;
    obs_t o;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t sb[$];

  pc_fetch_unit_if #(.XLEN(64), .STALL_CNT_W(16)) bus ();

  pc_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t a;
    a.pc = bus.pc_o;
    a.v  = bus.pc_valid_o;
    a.s  = bus.state_o;
    a.c  = bus.stall_cycles_o;
    a.m  = bus.misalign_o;
    return a;
  endfunction

  task automatic check(input int id, input obs_t e);
    obs_t a;
    logic [63:0] ns;
    a = sample();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL vec%0d: got pc=%h v=%b s=%b cnt=%0d mis=%b want pc=%h v=%b s=%b cnt=%0d mis=%b",
               id, a.pc, a.v, a.s, a.c, a.m,
               e.pc, e.v, e.s, e.c, e.m);
    end
    ns = e.pc + 64'd4;
    total++;
    if (bus.pc_next_seq_o !== ns) begin
      bad++;
      $display("FAIL vec%0d next_seq: got %h want %h",
               id, bus.pc_next_seq_o, ns);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.id, e.o);
    end
  end

  task automatic vec(
    input int id, input logic rst,
    input logic st, input logic rd,
    input logic [63:0] rpc, input logic tr,
    input logic hl, input logic rs, input logic rdy,
    input logic [63:0] epc, input logic ev,
    input logic [1:0] es, input logic [15:0] ec,
    input logic em);
    exp_t e;
    @(negedge clk);
    reset             = rst;
    bus.stall_i       = st;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = rpc;
    bus.trap_i        = tr;
    bus.halt_i        = hl;
    bus.resume_i      = rs;
    bus.fetch_ready_i = rdy;
    e.id = id;
    e.o  = '{pc: epc, v: ev, s: es, c: ec, m: em};
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t r;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.stall_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.trap_i        = 1'b0;
    bus.halt_i        = 1'b0;
    bus.resume_i      = 1'b0;
    bus.fetch_ready_i = 1'b1;

    //   id rst st rd rpc tr hl rs rdy | pc v s cnt mis
    vec(0, 1,0,0,64'h0,0,0,0,1, 64'h0,0,2'b00,0,0);
    vec(1, 0,0,0,64'h0,0,0,0,1, 64'h0,1,2'b01,0,0);
    vec(2, 0,0,0,64'h0,0,0,0,1, 64'h4,1,2'b01,0,0);
    vec(3, 0,0,0,64'h0,0,0,0,1, 64'h8,1,2'b01,0,0);
    vec(4, 0,1,0,64'h0,0,0,0,1, 64'h8,1,2'b01,1,0);
    vec(5, 0,1,0,64'h0,0,0,0,1, 64'h8,1,2'b01,2,0);
    vec(6, 0,1,0,64'h0,0,0,0,1, 64'h8,1,2'b01,3,0);
    vec(7, 0,0,1,64'h200,0,0,0,1, 64'h200,1,2'b01,0,0);
    vec(8, 0,0,0,64'h0,0,0,0,1, 64'h204,1,2'b01,0,0);
    vec(9, 0,1,1,64'h300,1,0,0,1, 64'h100,1,2'b01,0,0);
    vec(10,0,1,1,64'h300,0,0,0,1, 64'h300,1,2'b01,0,0);
    vec(11,0,0,0,64'h0,0,0,0,1, 64'h304,1,2'b01,0,0);
    vec(12,0,0,1,64'h40,0,0,0,1, 64'h40,1,2'b01,0,0);
    vec(13,0,0,0,64'h0,0,1,0,1, 64'h44,0,2'b10,0,0);
    vec(14,0,0,0,64'h0,0,0,0,1, 64'h44,0,2'b10,0,0);
    vec(15,0,1,0,64'h0,0,0,0,1, 64'h44,0,2'b10,0,0);
    vec(16,0,0,0,64'h0,0,1,1,1, 64'h44,1,2'b01,0,0);
    vec(17,0,0,0,64'h0,0,0,0,1, 64'h48,1,2'b01,0,0);
    vec(18,0,1,0,64'h0,0,0,0,1, 64'h48,1,2'b01,1,0);
    vec(19,0,0,1,64'hFFFF_FFFF_FFFF_FFFC,0,0,0,1,
        64'hFFFF_FFFF_FFFF_FFFC,1,2'b01,0,0);
    vec(20,0,0,0,64'h0,0,0,0,1, 64'h0,1,2'b01,0,0);
    vec(21,0,0,0,64'h0,0,0,0,0, 64'h0,1,2'b01,1,0);
    vec(22,0,0,0,64'h0,0,0,0,0, 64'h0,1,2'b01,2,0);
    vec(23,0,0,1,64'h202,0,0,0,1,
        AC ? 64'h100 : 64'h202,1,2'b01,0,AC);
    vec(24,0,0,0,64'h0,0,0,0,1,
        AC ? 64'h104 : 64'h206,1,2'b01,0,0);
    vec(25,0,0,0,64'h0,0,1,0,1,
        AC ? 64'h108 : 64'h20A,0,2'b10,0,0);
    vec(26,0,0,1,64'h500,0,0,0,1, 64'h500,0,2'b10,0,0);
    vec(27,0,0,0,64'h0,0,0,1,1, 64'h500,1,2'b01,0,0);
    vec(28,0,0,1,64'h202,1,0,0,1, 64'h100,1,2'b01,0,0);
    vec(29,0,0,0,64'h0,0,0,0,1, 64'h104,1,2'b01,0,0);
    vec(30,1,0,0,64'h0,0,0,0,1, 64'h0,0,2'b00,0,0);
    #1;
    r = '{pc: 64'h0, v: 1'b0, s: 2'b00, c: 16'd0, m: 1'b0};
    check(100, r);
    vec(31,0,0,0,64'h0,1,0,0,1, 64'h100,1,2'b01,0,0);
    vec(32,0,0,0,64'h0,0,0,0,1, 64'h104,1,2'b01,0,0);

    @(negedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
